boa_stage_if: RTL and testbench

Instruction fetch stage; the producer side of the IF/ID interface consumed by boa_stage_id. Keeps the fetch PC and issues word reads on the program bus. Delivers valid/PC/instruction/trap/cause to ID and accepts redirects from ID (jumps and predicted branches) and from later stages (mispredicts and traps).

---
 rtl/boa_pkg.sv | 31 +++
 rtl/boa_if_skid.sv | 49 ++++
 rtl/boa_stage_if.sv | 172 +++++++++++++++++
 tb/tb_boa_stage_if.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/boa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : boa_pkg
//  Purpose  : Shared types for the boa fetch front end: trap cause codes,
//             the 32-bit PC type, the IF/ID bundle and the fetch FSM states.
//  Revision : 1.0  initial release
// ============================================================================
package boa_pkg;

    localparam logic [3:0] cause_insn_misaligned = 4'd0;
    localparam logic [3:0] cause_insn_access     = 4'd1;

    typedef logic [31:0] pc_t;

    // One IF/ID transfer; pc is the word address [31:2].
    typedef struct packed {
        logic        valid;
        logic [29:0] pc;
        logic [31:0] insn;
        logic        trap;
        logic [3:0]  cause;
    } ifid_t;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_HALT = 2'd2
    } if_state_e;

endpackage
`default_nettype wire

// File: rtl/boa_if_skid.sv
`default_nettype none
// ============================================================================
//  Module   : boa_if_skid
//  Purpose  : One-entry skid buffer that parks a fetch result which returns
//             while ID is stalled.
//  Ports    : clk, rst (async, active low)
//             load_i  - capture entry_i (wins over pop_i)
//             pop_i   - release the stored entry
//             flush_i - drop the stored entry (wins over everything)
//             entry_i - bundle to store
//             entry_o - stored bundle
//             full_o  - an entry is held
//  Revision : 1.0  initial release
// ============================================================================
module boa_if_skid
    import boa_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load_i,
    input  logic  pop_i,
    input  logic  flush_i,
    input  ifid_t entry_i,
    output ifid_t entry_o,
    output logic  full_o
);

    ifid_t entry_q;
    logic  full_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_q <= '0;
            full_q  <= 1'b0;
        end else if (flush_i) begin
            full_q  <= 1'b0;
        end else if (load_i) begin
            entry_q <= entry_i;
            full_q  <= 1'b1;
        end else if (pop_i) begin
            full_q  <= 1'b0;
        end
    end

    assign entry_o = entry_q;
    assign full_o  = full_q;

endmodule
`default_nettype wire

// File: rtl/boa_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : boa_stage_if
//  Purpose  : Instruction fetch stage. Holds the fetch PC, issues one word
//             read at a time on the program bus and presents results to ID.
//  Ports    : clk, rst (async, active low)
//             q_valid/q_pc/q_insn/q_trap/q_cause - IF/ID bundle (registered)
//             fw_stall_if                          - ID cannot accept
//             fw_id_redir/fw_id_target             - ID redirect, [31:1]
//             fw_ex_redir/fw_ex_target             - late redirect, [31:1]
//             pbus_re/pbus_addr                    - read request, word addr
//             pbus_ready/pbus_rdata/pbus_fault     - read completion
//  Revision : 1.0  initial release
// ============================================================================
module boa_stage_if
    import boa_pkg::*;
#(
    parameter pc_t entrypoint = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        q_valid,
    output logic [29:0] q_pc,
    output logic [31:0] q_insn,
    output logic        q_trap,
    output logic [3:0]  q_cause,
    input  logic        fw_stall_if,
    input  logic        fw_id_redir,
    input  logic [30:0] fw_id_target,
    input  logic        fw_ex_redir,
    input  logic [30:0] fw_ex_target,
    output logic        pbus_re,
    output logic [29:0] pbus_addr,
    input  logic        pbus_ready,
    input  logic [31:0] pbus_rdata,
    input  logic        pbus_fault
);

    if_state_e   state_q, state_d;
    logic [29:0] pc_q, pc_d;
    logic [29:0] addr_q, addr_d;      // address of the read in flight
    logic        inflight_q, inflight_d;
    logic        squash_q, squash_d;  // in-flight read belongs to an old path
    logic        misal_q, misal_d;    // misaligned-target trap still to emit
    ifid_t       out_q, out_d;
    ifid_t       fetched, skid_entry;
    logic        skid_load, skid_pop, skid_flush, skid_full;
    logic        redir, fire, done;
    logic [30:0] target;

    // ID redirects are ignored once halted; only a late redirect restarts.
    assign redir  = fw_ex_redir | (fw_id_redir & (state_q != ST_HALT));
    assign target = fw_ex_redir ? fw_ex_target : fw_id_target;

    // A read in flight keeps its request up regardless of stall.
    assign pbus_re   = rst & (inflight_q |
                       ((state_q == ST_RUN) & ~fw_stall_if & ~misal_q));
    assign pbus_addr = inflight_q ? addr_q : pc_q;
    assign fire      = pbus_re & pbus_ready;
    assign done      = fire & ~squash_q;

    always_comb begin
        fetched       = '0;
        fetched.valid = 1'b1;
        fetched.pc    = pbus_addr;
        fetched.insn  = pbus_rdata;
        fetched.trap  = pbus_fault;
        fetched.cause = pbus_fault ? cause_insn_access : cause_insn_misaligned;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        out_d      = out_q;
        misal_d    = misal_q;
        squash_d   = fire ? 1'b0 : squash_q;
        inflight_d = pbus_re & ~pbus_ready;
        addr_d     = pbus_addr;
        skid_load  = 1'b0;
        skid_pop   = 1'b0;
        skid_flush = 1'b0;

        if (redir) begin
            pc_d        = target[30:1];
            misal_d     = target[0];
            out_d.valid = 1'b0;
            skid_flush  = 1'b1;
            state_d     = ST_RUN;
            squash_d    = pbus_re & ~pbus_ready;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (misal_q) begin
                        if (!fw_stall_if) begin
                            out_d.valid = 1'b1;
                            out_d.pc    = pc_q;
                            out_d.insn  = 32'h0;
                            out_d.trap  = 1'b1;
                            out_d.cause = cause_insn_misaligned;
                            misal_d     = 1'b0;
                            state_d     = ST_HALT;
                        end
                    end else if (fw_stall_if) begin
                        if (done) begin
                            skid_load = 1'b1;
                            pc_d      = pc_q + 30'd1;
                            state_d   = ST_HOLD;
                        end
                    end else if (done) begin
                        out_d   = fetched;
                        pc_d    = pc_q + 30'd1;
                        state_d = pbus_fault ? ST_HALT : ST_RUN;
                    end else begin
                        out_d.valid = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!fw_stall_if && skid_full) begin
                        out_d    = skid_entry;
                        skid_pop = 1'b1;
                        state_d  = skid_entry.trap ? ST_HALT : ST_RUN;
                    end
                end
                ST_HALT: begin
                    if (!fw_stall_if) begin
                        out_d.valid = 1'b0;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            pc_q       <= entrypoint[31:2];
            addr_q     <= '0;
            inflight_q <= 1'b0;
            squash_q   <= 1'b0;
            misal_q    <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            squash_q   <= squash_d;
            misal_q    <= misal_d;
            out_q      <= out_d;
        end
    end

    boa_if_skid u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .pop_i   (skid_pop),
        .flush_i (skid_flush),
        .entry_i (fetched),
        .entry_o (skid_entry),
        .full_o  (skid_full)
    );

    assign q_valid = out_q.valid;
    assign q_pc    = out_q.pc;
    assign q_insn  = out_q.insn;
    assign q_trap  = out_q.trap;
    assign q_cause = out_q.cause;

endmodule
`default_nettype wire

// File: tb/tb_boa_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : tb_boa_stage_if
//  Purpose  : Self-checking bench for boa_stage_if. A reactive program-bus
//             responder with variable latency, and a transaction-level model
//             of the instruction stream ID should see.
//  Revision : 1.0  initial release
// ============================================================================
module tb_boa_stage_if;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        q_valid, q_trap, pbus_re;
    logic [29:0] q_pc, pbus_addr;
    logic [31:0] q_insn;
    logic [3:0]  q_cause;
    logic        fw_stall_if = 1'b0, fw_id_redir = 1'b0, fw_ex_redir = 1'b0;
    logic [30:0] fw_id_target = '0, fw_ex_target = '0;
    logic        pbus_ready = 1'b0, pbus_fault = 1'b0;
    logic [31:0] pbus_rdata = '0;

    boa_stage_if dut (
        .clk(clk), .rst(rst),
        .q_valid(q_valid), .q_pc(q_pc), .q_insn(q_insn), .q_trap(q_trap), .q_cause(q_cause),
        .fw_stall_if(fw_stall_if),
        .fw_id_redir(fw_id_redir), .fw_id_target(fw_id_target),
        .fw_ex_redir(fw_ex_redir), .fw_ex_target(fw_ex_target),
        .pbus_re(pbus_re), .pbus_addr(pbus_addr),
        .pbus_ready(pbus_ready), .pbus_rdata(pbus_rdata), .pbus_fault(pbus_fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] insn;
        logic        trap;
        logic [3:0]  cause;
    } ent_t;

    int checks = 0;
    int errors = 0;

    // Reference model: what ID is shown, what is queued behind it, where
    // the sequential fetch stream is, and whether fetch has stopped.
    ent_t        mq[$];
    ent_t        cur;
    logic        cur_v     = 1'b0;
    logic        halted    = 1'b0;
    logic [29:0] exp_fetch = 30'h1000_0000;

    // Bus responder state.
    logic        busy = 1'b0, disc = 1'b0, bfault = 1'b0;
    logic [29:0] baddr = '0;
    logic [31:0] bdata = '0;
    int          cnt = 0, lat = 0, lat_force = 1, lat_max = 3, n_issue = 0;
    logic        poison = 1'b0, fault_en = 1'b0, rand_fault = 1'b0;
    logic [29:0] fault_addr = '0;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        if (a == 30'h1000_0000) return 32'h0000_0013;
        if (a == 30'h1000_0001) return 32'h0090_0093;
        return {a, 2'b01} * 32'h9E37_79B1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        cur_v = 1'b0; halted = 1'b0; exp_fetch = 30'h1000_0000;
        busy = 1'b0; disc = 1'b0; cnt = 0;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input logic st, input logic id, input logic [30:0] idt,
                        input logic ex, input logic [30:0] ext);
        logic        exp_re, rd, mis;
        logic [30:0] tgt;
        ent_t        e;
        fw_stall_if = st; fw_id_redir = id; fw_id_target = idt;
        fw_ex_redir = ex; fw_ex_target = ext;
        pbus_ready = 1'b0; pbus_rdata = $urandom; pbus_fault = 1'($urandom_range(1, 0));
        #1;
        exp_re = busy ? 1'b1 : (!st && !halted && mq.size() == 0);
        chk("pbus_re", pbus_re, exp_re);
        if (pbus_re && !busy) begin
            chk("req_addr", pbus_addr, exp_fetch);
            busy = 1'b1; cnt = 0; disc = 1'b0; baddr = pbus_addr; n_issue++;
            bdata  = poison ? 32'hDEAD_BEEF : mem_word(pbus_addr);
            bfault = (fault_en && pbus_addr == fault_addr) || (rand_fault && pbus_addr[2:0] == 3'd5);
            lat    = (lat_force >= 0) ? lat_force : int'($urandom_range(lat_max, 0));
        end else if (pbus_re && busy) begin
            chk("addr_stable", pbus_addr, baddr);
        end
        if (pbus_re && busy && cnt == lat) begin
            pbus_ready = 1'b1; pbus_rdata = bdata; pbus_fault = bfault;
        end
        #1;
        rd  = ex || (id && !(halted && mq.size() == 0));
        tgt = ex ? ext : idt;
        mis = tgt[0];
        if (rd && busy) disc = 1'b1;
        if (pbus_ready && !disc) begin
            e = '{pc: baddr, insn: bdata, trap: bfault, cause: bfault ? 4'd1 : 4'd0};
            mq.push_back(e);
            exp_fetch = exp_fetch + 30'd1;
            if (bfault) halted = 1'b1;
        end
        if (rd) begin
            cur_v = 1'b0;
            mq.delete();
            exp_fetch = tgt[30:1];
            halted = mis;
            if (mis) mq.push_back('{pc: tgt[30:1], insn: 32'h0, trap: 1'b1, cause: 4'd0});
        end else if (!st) begin
            if (mq.size() > 0) begin cur = mq.pop_front(); cur_v = 1'b1; end
            else cur_v = 1'b0;
        end
        @(posedge clk); #1;
        if (pbus_ready) busy = 1'b0; else if (busy) cnt++;
        chk("q_valid", q_valid, cur_v);
        if (cur_v) begin
            chk("q_pc", q_pc, cur.pc);
            chk("q_insn", q_insn, cur.insn);
            chk("q_trap", q_trap, cur.trap);
            chk("q_cause", q_cause, cur.cause);
        end
        @(negedge clk);
    endtask

    task automatic run(input int n, input int stall_pct);
        for (int i = 0; i < n; i++)
            step(int'($urandom_range(99, 0)) < stall_pct, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int          n0, r;
        logic [30:0] t;
        logic        st, id, ex;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q_valid", q_valid, 1'b0);
        chk("rst_q_pc", q_pc, 30'h0);
        chk("rst_q_insn", q_insn, 32'h0);
        chk("rst_q_trap", q_trap, 1'b0);
        chk("rst_q_cause", q_cause, 4'h0);
        chk("rst_pbus_re", pbus_re, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Straight-line fetch, one-cycle bus latency.
        lat_force = 1;
        run(6, 0);

        // Stall for three cycles with a read completing under it.
        step(1'b0, 1'b0, '0, 1'b0, '0);
        repeat (3) step(1'b1, 1'b0, '0, 1'b0, '0);
        run(4, 0);

        // ID redirect while a poisoned read is outstanding.
        lat_force = 2; poison = 1'b1;
        n0 = n_issue;
        for (int g = 0; g < 20 && n_issue == n0; g++) step(1'b0, 1'b0, '0, 1'b0, '0);
        chk("issue_wait", n_issue != n0, 1'b1);
        poison = 1'b0;
        step(1'b0, 1'b1, 31'h2000_0002, 1'b0, '0);
        run(8, 0);

        // Late redirect beats ID redirect in the same cycle.
        lat_force = 0;
        step(1'b0, 1'b1, 31'h2000_0080, 1'b1, 31'h4000_0000);
        run(5, 0);

        // Misaligned ID target: trap, halt, ID redirect ignored, late restart.
        step(1'b0, 1'b1, 31'h2000_0001, 1'b0, '0);
        step(1'b1, 1'b0, '0, 1'b0, '0);
        run(4, 0);
        step(1'b0, 1'b1, 31'h2000_0040, 1'b0, '0);
        run(3, 0);
        step(1'b0, 1'b0, '0, 1'b1, 31'h2000_0008);
        run(6, 0);

        // Access fault, delivered under random stalls, then a late restart.
        lat_force = -1; lat_max = 2;
        fault_en = 1'b1; fault_addr = exp_fetch + 30'd2;
        run(20, 30);
        fault_en = 1'b0;
        step(1'b0, 1'b0, '0, 1'b1, 31'h2000_0100);
        run(4, 0);

        // PC wrap at the top of the address space, zero-latency bus.
        lat_force = 0;
        step(1'b0, 1'b0, '0, 1'b1, 31'h7FFF_FFFC);
        run(5, 0);

        // Reset in the middle of a transaction.
        lat_force = 3;
        run(2, 0);
        rst = 1'b0; pbus_ready = 1'b0;
        #1;
        chk("midrst_q_valid", q_valid, 1'b0);
        chk("midrst_pbus_re", pbus_re, 1'b0);
        @(negedge clk);
        model_reset();
        rst = 1'b1;
        run(6, 0);

        // Randomised traffic: stalls, latencies, redirects, faults.
        lat_force = -1; lat_max = 3; rand_fault = 1'b1;
        for (int i = 0; i < 600; i++) begin
            r  = int'($urandom_range(99, 0));
            st = (int'($urandom_range(3, 0)) == 0);
            id = (r < 6);
            ex = (r >= 97) || (halted && r >= 85);
            t  = 31'($urandom);
            t[0] = (int'($urandom_range(9, 0)) == 0);
            step(st, id, t, ex, {t[30:1], 1'b0});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
